lock_controller: RTL
====================

# lock_controller

Sequencing controller that sits above the `keypad` code checker and turns it into a complete door lock. It gates the keypad's `enable`, counts digit strobes, and samples the keypad's `correct` flag once a full code has been entered. It also clears the keypad between attempts, holds the unlock output for a fixed time, and enforces a lockout after repeated failures. The block sits between the key-scan front end and the door actuator/alarm.

## Interface
Parameters:
- `DIGITS`, 4: digits per code attempt (≥1).
- `MAX_FAILS`, 3: consecutive failed attempts that trigger lockout (≥1).
- `UNLOCK_CYCLES`, 50: cycles `unlock` is held high after a correct code (≥1).
- `LOCKOUT_CYCLES`, 200: cycles spent in lockout (≥1).
- `TIMEOUT_CYCLES`, 100: maximum idle cycles between digits before a partial entry is abandoned (≥1).

Ports (clock and reset first):
- `clk` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `key_valid` in 1: one-cycle strobe for each digit pressed; the same digit is presented to the keypad on `number`.
- `code_ok` in 1: keypad `correct` output.
- `kp_enable` out 1: drives keypad `enable`.
- `kp_clear` out 1: one-cycle pulse that restarts the keypad's digit sequence.
- `unlock` out 1: door release.
- `alarm` out 1: lockout indicator (see Configuration).
- `fail_cnt` out $clog2(MAX_FAILS+1): count of consecutive failures.
- `busy` out 1: high in any state other than IDLE.

## Operation
FSM states: IDLE, ENTRY, CHECK, UNLOCKED, LOCKOUT.

- **IDLE**
  - `kp_enable`=1.
  - `key_valid` sets digit_cnt=1 and clears the timer.
  - Next state is ENTRY, or CHECK if DIGITS==1.
- **ENTRY**
  - `kp_enable`=1.
  - Each `key_valid` increments digit_cnt and clears the timer. When digit_cnt reaches DIGITS, the next state is CHECK.
  - With no `key_valid`, the timer increments. When it reaches TIMEOUT_CYCLES: go to IDLE, pulse `kp_clear`, leave `fail_cnt` unchanged.
- **CHECK** (exactly one cycle)
  - `kp_enable`=0 and `code_ok` is sampled.
  - If `code_ok`=1: go to UNLOCKED and set `fail_cnt`=0.
  - If `code_ok`=0: increment `fail_cnt`. If the new value equals MAX_FAILS, go to LOCKOUT; otherwise go to IDLE.
  - `kp_clear` pulses on the CHECK-exit edge (high during the first cycle of the next state).
- **UNLOCKED**
  - `unlock`=1 for exactly UNLOCK_CYCLES cycles, then IDLE.
- **LOCKOUT**
  - Held for exactly LOCKOUT_CYCLES cycles.
  - On exit: `fail_cnt`=0, go to IDLE.
- `key_valid` is ignored in CHECK, UNLOCKED and LOCKOUT.
- A single shared down/up timer serves the timeout, unlock and lockout durations. It is sized by $clog2 of the largest of these parameters.
- `fail_cnt` saturates at MAX_FAILS and never wraps.

## Timing
- Reset (asynchronous, `reset`=0):
  - State is IDLE and digit_cnt, timer and `fail_cnt` are 0.
  - Outputs: `kp_enable`=1, `kp_clear`=0, `unlock`=0, `alarm`=0, `busy`=0.
- Reset asserted mid-operation aborts immediately. `unlock` and `alarm` drop asynchronously.
- Latency:
  - The final `key_valid` at edge N puts the FSM in CHECK for cycle N+1.
  - `unlock` or the lockout begins at cycle N+2.
  - `code_ok` must be valid during the CHECK cycle. The keypad's `correct` output is registered on the final digit, so it meets this.
- Timeout boundary: a `key_valid` arriving on the same cycle the timer reaches TIMEOUT_CYCLES wins. The digit is counted and the timer is cleared.
- `busy` is registered from the state and is high from the cycle after entering ENTRY.
- `kp_enable` deasserts in the CHECK cycle, so keypresses during evaluation never reach the keypad.

## Configuration
- `LOCK_ALARM_EN` defined:
  - `alarm`=1 throughout LOCKOUT.
  - `alarm` also pulses for one cycle on each failed CHECK.
- `LOCK_ALARM_EN` undefined:
  - `alarm` is tied to 0 and no alarm logic is synthesised.
  - Lockout timing is unchanged.

## Test plan
- **Correct code.** Reset, then four `key_valid` strobes with `code_ok`=1 in CHECK.
  - `unlock`=1 for 50 cycles starting 2 cycles after the 4th strobe.
  - `fail_cnt`=0.
  - One `kp_clear` pulse.
- **Single bad code.** Four strobes with `code_ok`=0.
  - `fail_cnt`=1, state returns to IDLE, `unlock` stays 0.
  - With `LOCK_ALARM_EN`, `alarm` pulses once.
- **Lockout.** Three consecutive bad codes.
  - LOCKOUT for 200 cycles with `busy`=1 and `kp_enable`=0.
  - Strobes during LOCKOUT are ignored.
  - After lockout, `fail_cnt`=0.
  - `alarm`=1 throughout when `LOCK_ALARM_EN` is defined, and 0 when it is undefined.
- **Entry timeout.** Two strobes followed by 100 idle cycles.
  - IDLE with a `kp_clear` pulse, `fail_cnt` unchanged.
  - A strobe on the exact timeout cycle keeps the FSM in ENTRY with digit_cnt=3.
- **Mid-operation reset.** Assert `reset`=0 during UNLOCKED and during LOCKOUT.
  - `unlock`/`alarm` drop immediately and all outputs return to their reset values.

Source files
------------

// File: rtl/lock_controller.sv
// lock_controller: sequences a keypad code checker into a door lock with unlock hold,
// entry timeout and failure lockout. Define LOCK_ALARM_EN to build the alarm output.
module lock_controller #(
    parameter int DIGITS         = 4,
    parameter int MAX_FAILS      = 3,
    parameter int UNLOCK_CYCLES  = 50,
    parameter int LOCKOUT_CYCLES = 200,
    parameter int TIMEOUT_CYCLES = 100
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           key_valid,
    input  logic                           code_ok,
    output logic                           kp_enable,
    output logic                           kp_clear,
    output logic                           unlock,
    output logic                           alarm,
    output logic [$clog2(MAX_FAILS+1)-1:0] fail_cnt,
    output logic                           busy
);

    localparam int FW       = $clog2(MAX_FAILS + 1);
    localparam int DW       = $clog2(DIGITS + 1);
    localparam int T_MAX_UL = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
    localparam int T_MAX    = (T_MAX_UL > TIMEOUT_CYCLES) ? T_MAX_UL : TIMEOUT_CYCLES;
    localparam int TW       = $clog2(T_MAX + 1);

    localparam logic [DW-1:0] DIGIT_FINAL  = DW'(DIGITS - 1);
    localparam logic [FW-1:0] FAIL_FINAL   = FW'(MAX_FAILS - 1);
    localparam logic [FW-1:0] FAIL_SAT     = FW'(MAX_FAILS);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] UNLOCK_LAST  = TW'(UNLOCK_CYCLES - 1);
    localparam logic [TW-1:0] LOCKOUT_LAST = TW'(LOCKOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        ENTRY,
        CHECK,
        UNLOCKED,
        LOCKOUT
    } state_t;

    state_t          state, state_next;
    logic [DW-1:0]   digit_cnt, digit_next;
    logic [TW-1:0]   timer, timer_next;
    logic [FW-1:0]   fail_next;
    logic            clear_next;

    // NOTE: every register updates with <= so all of them see the same pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            digit_cnt <= '0;
            timer     <= '0;
            fail_cnt  <= '0;
            kp_clear  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_next;
            digit_cnt <= digit_next;
            timer     <= timer_next;
            fail_cnt  <= fail_next;
            kp_clear  <= clear_next;
            busy      <= (state != IDLE);
        end
    end

    // NOTE: every output of this block gets a default first, so no path infers a latch.
    always_comb begin
        state_next = state;
        digit_next = digit_cnt;
        timer_next = timer;
        fail_next  = fail_cnt;
        clear_next = 1'b0;
        kp_enable  = 1'b0;
        unlock     = 1'b0;

        case (state)
            IDLE: begin
                kp_enable = 1'b1;
                if (key_valid) begin
                    digit_next = DW'(1);
                    timer_next = '0;
                    state_next = (DIGITS == 1) ? CHECK : ENTRY;
                end
            end

            ENTRY: begin
                kp_enable = 1'b1;
                // A digit on the timeout cycle takes priority over abandoning the entry.
                if (key_valid) begin
                    digit_next = digit_cnt + DW'(1);
                    timer_next = '0;
                    if (digit_cnt == DIGIT_FINAL) begin
                        state_next = CHECK;
                    end
                end else if (timer == TIMEOUT_LAST) begin
                    state_next = IDLE;
                    digit_next = '0;
                    timer_next = '0;
                    clear_next = 1'b1;
                end else begin
                    timer_next = timer + TW'(1);
                end
            end

            CHECK: begin
                digit_next = '0;
                timer_next = '0;
                clear_next = 1'b1;
                if (code_ok) begin
                    fail_next  = '0;
                    state_next = UNLOCKED;
                end else if (fail_cnt >= FAIL_FINAL) begin
                    fail_next  = FAIL_SAT;
                    state_next = LOCKOUT;
                end else begin
                    fail_next  = fail_cnt + FW'(1);
                    state_next = IDLE;
                end
            end

            UNLOCKED: begin
                unlock = 1'b1;
                if (timer == UNLOCK_LAST) begin
                    timer_next = '0;
                    state_next = IDLE;
                end else begin
                    timer_next = timer + TW'(1);
                end
            end

            LOCKOUT: begin
                if (timer == LOCKOUT_LAST) begin
                    timer_next = '0;
                    fail_next  = '0;
                    state_next = IDLE;
                end else begin
                    timer_next = timer + TW'(1);
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

`ifdef LOCK_ALARM_EN
    logic fail_flag;

    // One-cycle pulse in the cycle after a rejected code; lockout holds the alarm on.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fail_flag <= 1'b0;
        end else begin
            fail_flag <= (state == CHECK) && !code_ok;
        end
    end

    assign alarm = fail_flag || (state == LOCKOUT);
`else
    assign alarm = 1'b0;
`endif

endmodule
